// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage RV32 core.
// Drives the PC and pipeline-register write enables, bubbles and the IF/ID flush.
// It handles load-use stalls, taken-branch flushes, multi-cycle MUL/DIV occupancy
// of EX (start/done handshake with timeout) and the whole-pipe freeze on a
// data-memory wait. Operand forwarding covers every other hazard.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating performance
// counters (stall_cycles, flush_count, freeze_cycles).
module hazard_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  input  logic             md_done,
  input  logic             branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Bubble,
  output logic             md_start,
  output logic             md_timeout,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles
`endif
);

  localparam int unsigned TmoW = $clog2(MD_TIMEOUT);
  // Counter value seen in the last MD_WAIT cycle before the op is abandoned.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StMdWait = 2'b01,
    StMdDone = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            pend_q, pend_d;

  logic freeze;
  logic load_use;
  logic tmo_hit;

  assign freeze   = EX_MEM_MemAccess && !dmem_ready;
  assign load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                    ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  // A completion (live or remembered from a freeze) always beats the timeout.
  assign tmo_hit  = (state_q == StMdWait) && !md_done && !pend_q && (cnt_q == TmoLast);

  assign state      = state_q;
  assign md_timeout = tmo_q;

  // State register with synchronous active-low reset; reset abandons any MUL/DIV op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: a freeze holds everything except catching an early md_done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    if (freeze) begin
      if ((state_q == StMdWait) && md_done) begin
        pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          // Same priority as the outputs: branch and load-use pre-empt the start.
          if (!branch_taken && !load_use && ID_EX_MulDiv) begin
            state_d = StMdWait;
            cnt_d   = '0;
            pend_d  = 1'b0;
          end
        end
        StMdWait: begin
          cnt_d = cnt_q + 1'b1;
          if (md_done || pend_q) begin
            state_d = StMdDone;
            pend_d  = 1'b0;
          end else if (cnt_q == TmoLast) begin
            state_d = StRun;
            tmo_d   = 1'b1;
          end
        end
        StMdDone: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  // Output decode: reset, freeze, MD_WAIT occupancy, then branch > load-use > MUL/DIV start.
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    EX_MEM_Bubble = 1'b0;
    md_start      = 1'b0;
    if (!rst) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
    end else if (freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (state_q == StMdWait) begin
      // EX is busy: hold the front end and keep feeding NOPs into MEM.
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      EX_MEM_Bubble = 1'b1;
      if (tmo_hit) begin
        // Drop the abandoned op out of EX.
        ID_EX_Bubble = 1'b1;
      end
    end else begin
      // RUN or the single MD_DONE cycle (which captures the result via EX_MEM_Write).
      if (branch_taken) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (load_use) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end else if ((state_q == StRun) && ID_EX_MulDiv) begin
        md_start      = 1'b1;
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Write  = 1'b0;
        EX_MEM_Bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] frz_q, frz_d;

  assign stall_cycles  = stall_q;
  assign flush_count   = flush_q;
  assign freeze_cycles = frz_q;

  // Saturating event counters; stalls caused by a freeze are counted only as freezes.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    frz_d   = frz_q;
    if (!PC_Write && !freeze && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (IF_ID_Flush && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
    if (freeze && (frz_q != '1)) begin
      frz_d = frz_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
      frz_q   <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      frz_q   <= frz_d;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan scenarios followed by random
// stimulus, every cycle compared against a cycle-level reference model.
module tb_hazard_stall_ctrl;

  localparam int MdTmo    = 8;
  localparam int ModeRun  = 0;
  localparam int ModeWait = 1;
  localparam int ModeDone = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, mul_div, md_done, br, acc, rdy;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
  logic       EX_MEM_Write, EX_MEM_Bubble, md_start, md_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, freeze_cycles;
  int          p_stall, p_flush, p_frz;
`endif

  hazard_stall_ctrl #(
    .MD_TIMEOUT(MdTmo),
    .CNT_W     (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_Rs1       (rs1),
    .IF_ID_Rs2       (rs2),
    .ID_EX_Rd        (rd),
    .ID_EX_MemRead   (mem_read),
    .ID_EX_MulDiv    (mul_div),
    .md_done         (md_done),
    .branch_taken    (br),
    .EX_MEM_MemAccess(acc),
    .dmem_ready      (rdy),
    .PC_Write        (PC_Write),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Write     (ID_EX_Write),
    .ID_EX_Bubble    (ID_EX_Bubble),
    .EX_MEM_Write    (EX_MEM_Write),
    .EX_MEM_Bubble   (EX_MEM_Bubble),
    .md_start        (md_start),
    .md_timeout      (md_timeout),
    .state           (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .freeze_cycles   (freeze_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: mode, unfrozen MD_WAIT cycles elapsed, sticky flag, early done.
  int         m_mode = ModeRun;
  int         m_wait = 0;
  bit         m_tmo  = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_frz;
  int         n_mode, n_wait;
  bit         n_tmo, n_pend;
  logic [7:0] e_out;
  int         start_seen;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs {PC_W, IFID_W, IFID_Flush, IDEX_W, IDEX_Bub, EXMEM_W, EXMEM_Bub, md_start}.
  task automatic model_eval();
    bit pc, ifw, fl, idw, idb, exw, exb, st, lu;
    pc = 1; ifw = 1; fl = 0; idw = 1; idb = 0; exw = 1; exb = 0; st = 0;
    n_mode = m_mode; n_wait = m_wait; n_tmo = m_tmo; n_pend = m_pend;
    m_frz = acc && !rdy;
    lu = mem_read && (rd != 0) && ((rd == rs1) || (rd == rs2));
    if (!rst) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; fl = 1; idb = 1; exb = 1;
      n_mode = ModeRun; n_wait = 0; n_tmo = 0; n_pend = 0;
    end else if (m_frz) begin
      pc = 0; ifw = 0; idw = 0; exw = 0;
      if (m_mode == ModeWait && md_done) n_pend = 1;
    end else if (m_mode == ModeWait) begin
      pc = 0; ifw = 0; idw = 0; exw = 0; exb = 1;
      if (md_done || m_pend) begin
        n_mode = ModeDone; n_pend = 0;
      end else if (m_wait + 1 == MdTmo) begin
        n_mode = ModeRun; n_tmo = 1; idb = 1;
      end else begin
        n_wait = m_wait + 1;
      end
    end else begin
      if (br) begin
        fl = 1; idb = 1;
      end else if (lu) begin
        pc = 0; ifw = 0; idb = 1;
      end else if (m_mode == ModeRun && mul_div) begin
        st = 1; pc = 0; ifw = 0; idw = 0; exw = 0; exb = 1;
        n_mode = ModeWait; n_wait = 0; n_pend = 0;
      end
      if (m_mode == ModeDone) n_mode = ModeRun;
    end
    e_out = {pc, ifw, fl, idw, idb, exw, exb, st};
  endtask

  // One clock: inputs already applied after the falling edge; check, clock, commit.
  task automatic step(input string tag);
    #1;
    model_eval();
    check({tag, ":outs"}, {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
                           EX_MEM_Write, EX_MEM_Bubble, md_start}, e_out);
    check({tag, ":state"}, {6'd0, state}, 8'(m_mode));
    check({tag, ":tmo"}, {7'd0, md_timeout}, {7'd0, m_tmo});
    if (md_start === 1'b1) start_seen++;
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (!rst) begin
      p_stall = 0; p_flush = 0; p_frz = 0;
    end else begin
      if (!e_out[7] && !m_frz) p_stall++;
      if (e_out[5]) p_flush++;
      if (m_frz) p_frz++;
    end
`endif
    m_mode = n_mode; m_wait = n_wait; m_tmo = n_tmo; m_pend = n_pend;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1; mem_read = 0; mul_div = 0; md_done = 0; br = 0; acc = 0; rdy = 1;
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
  endtask

  initial begin
    set_idle();
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    step("reset");
    step("reset");
    rst = 1;
    step("idle");
    step("idle");

    // Load x5, consumer reads x5 as rs2: one stall cycle, then the bubble clears it.
    mem_read = 1; rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5;
    step("lu_rs2");
    mem_read = 0;
    step("lu_after");
    // Load into x0 never stalls.
    mem_read = 1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    step("lu_x0");
    // Taken branch coincident with load-use: flush wins, no stall.
    mem_read = 1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd2; br = 1;
    step("br_lu");
    set_idle();
    step("idle");

    // MUL, md_done five cycles after md_start.
    start_seen = 0;
    mul_div = 1;
    step("md_start");
    for (int i = 0; i < 5; i++) begin
      md_done = (i == 4);
      step("md_wait");
    end
    md_done = 0;
    step("md_done");
    mul_div = 0;
    step("md_back");
    check("md_start_pulses", 8'(start_seen), 8'd1);

    // md_done arrives during a 3-cycle freeze in MD_WAIT.
    mul_div = 1;
    step("frz_start");
    step("frz_wait");
    acc = 1; rdy = 0;
    step("frz1");
    md_done = 1;
    step("frz2");
    md_done = 0;
    step("frz3");
    acc = 0; rdy = 1;
    step("frz_release");
    check("frz_to_done", {6'd0, state}, 8'd2);
    step("frz_done");
    mul_div = 0;
    step("frz_back");

    // Timeout: md_done never comes.
    mul_div = 1;
    step("tmo_start");
    for (int i = 0; i < MdTmo; i++) step("tmo_wait");
    mul_div = 0;
    check("tmo_flag", {7'd0, md_timeout}, 8'd1);
    check("tmo_state", {6'd0, state}, 8'd0);
    for (int i = 0; i < 3; i++) step("tmo_sticky");

    // Reset in the middle of MD_WAIT.
    start_seen = 0;
    mul_div = 1;
    step("rst_md_start");
    step("rst_md_wait");
    step("rst_md_wait");
    rst = 0; mul_div = 0;
    step("rst_mid");
    rst = 1;
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_tmo", {7'd0, md_timeout}, 8'd0);
    step("rst_release");
    step("rst_release");
    check("rst_no_restart", 8'(start_seen), 8'd1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 59) != 0);
      rs1      = 5'($urandom_range(0, 3) * 5);
      rs2      = 5'($urandom_range(0, 3) * 5);
      rd       = 5'($urandom_range(0, 3) * 5);
      mem_read = ($urandom_range(0, 9) < 3);
      mul_div  = ($urandom_range(0, 3) == 0);
      md_done  = ($urandom_range(0, 9) < 2);
      br       = ($urandom_range(0, 19) < 3);
      acc      = ($urandom_range(0, 9) < 3);
      rdy      = ($urandom_range(0, 1) == 1);
      step("rand");
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", stall_cycles[7:0], 8'(p_stall));
    check("perf_flush", flush_count[7:0], 8'(p_flush));
    check("perf_freeze", freeze_cycles[7:0], 8'(p_frz));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core; sits beside the operand-forwarding logic and drives all pipeline-register write enables, bubbles and flushes.
- Resolves load-use stalls, taken-branch flushes, multi-cycle MUL/DIV occupancy of EX (start/done handshake with timeout), and whole-pipe freeze on data-memory wait.
- Forwarding covers everything else; this block only sequences the cases forwarding cannot.

Parameters:
- MD_TIMEOUT, 64, max cycles in MD_WAIT before the op is abandoned (>=2)
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-low
- IF_ID_Rs1  in  5  source reg 1 of instruction in ID
- IF_ID_Rs2  in  5  source reg 2 of instruction in ID
- ID_EX_Rd  in  5  destination of instruction in EX
- ID_EX_MemRead  in  1  EX instruction is a load
- ID_EX_MulDiv  in  1  EX instruction is a multi-cycle MUL/DIV
- md_done  in  1  one-cycle pulse from MUL/DIV unit, result valid
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- EX_MEM_MemAccess  in  1  MEM stage performing a load/store
- dmem_ready  in  1  data memory completes access this cycle
- PC_Write  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  clear IF/ID to NOP
- ID_EX_Write  out  1  ID/EX register enable
- ID_EX_Bubble  out  1  load NOP into ID/EX
- EX_MEM_Write  out  1  EX/MEM register enable
- EX_MEM_Bubble  out  1  load NOP into EX/MEM
- md_start  out  1  one-cycle start pulse to MUL/DIV unit
- md_timeout  out  1  sticky error flag
- state  out  2  FSM state: 00 RUN, 01 MD_WAIT, 10 MD_DONE

Behaviour:
- Default (RUN, no hazard): all *_Write=1; Bubble, Flush, md_start=0.
- Reset (rst low at edge): state RUN, timeout counter 0, md_timeout 0, done-pending 0. Outputs while rst low: all *_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1, EX_MEM_Bubble=1, md_start=0. Reset mid-MD_WAIT abandons the op; md_start is not reissued.
- Priority per cycle, highest first:
  1. Freeze: EX_MEM_MemAccess && !dmem_ready. All *_Write=0, no bubble, flush or md_start. FSM, counter and md_timeout hold. branch_taken ignored (re-presented next cycle). md_done seen during freeze sets done-pending.
  2. MD_WAIT: PC_Write=IF_ID_Write=ID_EX_Write=0; EX_MEM_Bubble=1. Counter +1 per unfrozen cycle. md_done or done-pending -> MD_DONE, clear pending. Counter reaching MD_TIMEOUT-1 without done -> set md_timeout, go RUN, op dropped (EX_MEM_Bubble=1, ID_EX_Bubble=1 that cycle).
  3. MD_DONE (1 cycle): EX_MEM_Write=1 captures result; ID_EX_Write=1; front end runs; evaluate 4-5 normally; -> RUN.
  4. RUN && branch_taken: PC_Write=1 (redirect), IF_ID_Flush=1, ID_EX_Bubble=1. Overrides load-use.
  5. RUN && load-use: ID_EX_MemRead && ID_EX_Rd!=0 && (ID_EX_Rd==IF_ID_Rs1 || ID_EX_Rd==IF_ID_Rs2). PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. Exactly one cycle per occurrence.
  6. RUN && ID_EX_MulDiv (not frozen): md_start=1, front stalled (PC/IF_ID/ID_EX_Write=0), EX_MEM_Bubble=1; -> MD_WAIT, counter 0. md_done in the same cycle as md_start is ignored.
- md_start asserts exactly once per MUL/DIV instruction.
- Outputs are combinational from state plus inputs; no combinational path from md_done to md_start.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles, flush_count, freeze_cycles (each CNT_W bits, saturating at all-ones, cleared by reset). stall_cycles increments in any cycle with PC_Write=0 not due to freeze; flush_count increments per IF_ID_Flush outside reset; freeze_cycles increments per freeze cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load x5, next instruction uses x5 as rs2 -> exactly 1 cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; ID_EX_Rd=0 case -> no stall.
- branch_taken=1 coincident with load-use -> PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1, no stall.
- MUL with md_done 5 cycles after md_start -> md_start 1 pulse, state 00->01 (5 cycles)->10->00, EX_MEM_Write=1 only in MD_DONE.
- md_done arriving during 3-cycle freeze in MD_WAIT -> all *_Write=0 for 3 cycles, then MD_DONE immediately after freeze.
- MD_TIMEOUT=8, md_done never -> md_timeout=1 after 8 MD_WAIT cycles, state 00, flag sticky until rst low.
- rst low during MD_WAIT -> next cycle state 00, md_timeout 0, no md_start on release.
